// File: rtl/song_pkg.sv
// Shared definitions for the multi-song ROM reader: reader state encoding
// and the default field widths used by the top level.
package song_pkg;

  localparam int DEF_SONG_BITS      = 2;
  localparam int DEF_ADDR_BITS      = 5;
  localparam int DEF_NOTE_WIDTH     = 6;
  localparam int DEF_DURATION_WIDTH = 6;

  // PAUSED must stay at 0: the state flop clears to all-zero on reset.
  typedef enum logic [2:0] {
    PAUSED  = 3'd0,
    FETCH   = 3'd1,
    LATCH   = 3'd2,
    WAIT    = 3'd3,
    ADVANCE = 3'd4
  } state_t;

endpackage

// File: rtl/dffr.sv
// Generic register with synchronous active-high clear; the only storage
// primitive used by the song reader.
module dffr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // NOTE: non-blocking so every flop samples pre-edge values, whatever the block order.
  always_ff @(posedge clk) begin
    if (i_rst) o_q <= '0;
    else       o_q <= i_d;
  end

endmodule

// File: rtl/duration_scaler.sv
// Halves a note duration in fast-forward/rewind so skimming plays faster,
// never turning an audible (non-zero) duration into silence.
module duration_scaler #(
  parameter int DURATION_WIDTH = 6
) (
  input  logic                      i_halve,
  input  logic [DURATION_WIDTH-1:0] i_duration,
  output logic [DURATION_WIDTH-1:0] o_duration
);

  logic [DURATION_WIDTH-1:0] w_half;

  assign w_half = i_duration >> 1;

  always_comb begin
    o_duration = i_duration;
    if (i_halve && (i_duration != '0))
      o_duration = (w_half == '0) ? DURATION_WIDTH'(1) : w_half;
  end

endmodule

// File: rtl/multi_song_reader.sv
// Walks the note table of the selected song, one entry per note_done,
// presenting each {note, duration} to the note player with a new_note pulse.
module multi_song_reader
  import song_pkg::*;
#(
  parameter int SONG_BITS      = DEF_SONG_BITS,
  parameter int ADDR_BITS      = DEF_ADDR_BITS,
  parameter int NOTE_WIDTH     = DEF_NOTE_WIDTH,
  parameter int DURATION_WIDTH = DEF_DURATION_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 play,
  input  logic [SONG_BITS-1:0]                 song,
  input  logic                                 note_done,
  input  logic                                 ff,
  input  logic                                 rewind,
  input  logic                                 loop,
  output logic [SONG_BITS+ADDR_BITS-1:0]       rom_addr,
  input  logic [NOTE_WIDTH+DURATION_WIDTH-1:0] rom_data,
  output logic [NOTE_WIDTH-1:0]                note,
  output logic [DURATION_WIDTH-1:0]            duration,
  output logic                                 new_note,
  output logic                                 song_done,
  output logic [ADDR_BITS-1:0]                 index
);

  logic [2:0]                r_state;
  state_t                    w_state;
  state_t                    w_state_nxt;
  logic [SONG_BITS-1:0]      r_song_q;
  logic [ADDR_BITS-1:0]      r_index;
  logic [ADDR_BITS-1:0]      w_index_nxt;
  logic [NOTE_WIDTH-1:0]     r_note;
  logic [NOTE_WIDTH-1:0]     w_note_nxt;
  logic [DURATION_WIDTH-1:0] r_duration;
  logic [DURATION_WIDTH-1:0] w_duration_nxt;
  logic                      r_new_note;
  logic                      w_new_note_nxt;
  logic                      r_song_done;
  logic                      w_song_done_nxt;

  logic [NOTE_WIDTH-1:0]     w_rom_note;
  logic [DURATION_WIDTH-1:0] w_rom_duration;
  logic [DURATION_WIDTH-1:0] w_scaled_duration;
  logic                      w_rom_zero_entry;
  logic                      w_latched_zero_entry;
  logic                      w_song_change;
  logic                      w_end_of_song;

  assign w_state = state_t'(r_state);

  assign w_rom_note     = rom_data[NOTE_WIDTH+DURATION_WIDTH-1:DURATION_WIDTH];
  assign w_rom_duration = rom_data[DURATION_WIDTH-1:0];

  duration_scaler #(
    .DURATION_WIDTH (DURATION_WIDTH)
  ) u_duration_scaler (
    .i_halve    (ff | rewind),
    .i_duration (w_rom_duration),
    .o_duration (w_scaled_duration)
  );

  assign w_song_change        = (song != r_song_q);
  assign w_rom_zero_entry     = (w_rom_note == '0) && (w_rom_duration == '0);
  // Scaling keeps non-zero durations non-zero, so the latched pair still marks a terminator.
  assign w_latched_zero_entry = (r_note == '0) && (r_duration == '0);
  assign w_end_of_song        = (rewind ? (r_index == '0) : (&r_index)) || w_latched_zero_entry;

  // NOTE: defaults first so no branch leaves a signal unassigned (no latch inferred).
  always_comb begin
    w_state_nxt     = w_state;
    w_index_nxt     = r_index;
    w_note_nxt      = r_note;
    w_duration_nxt  = r_duration;
    w_new_note_nxt  = 1'b0;
    w_song_done_nxt = 1'b0;

    if (w_song_change) begin
      w_state_nxt = PAUSED;
      w_index_nxt = '0;
    end else if (!play) begin
      w_state_nxt = PAUSED;
    end else begin
      case (w_state)
        PAUSED: w_state_nxt = FETCH;
        FETCH:  w_state_nxt = LATCH;
        LATCH: begin
          w_note_nxt     = w_rom_note;
          w_duration_nxt = w_scaled_duration;
          if (w_rom_zero_entry) begin
            w_state_nxt = ADVANCE;
          end else begin
            w_state_nxt    = WAIT;
            w_new_note_nxt = 1'b1;
          end
        end
        WAIT: begin
          if (note_done) w_state_nxt = ADVANCE;
        end
        ADVANCE: begin
          if (w_end_of_song) begin
            w_index_nxt     = '0;
            w_song_done_nxt = 1'b1;
            w_state_nxt     = loop ? FETCH : PAUSED;
          end else begin
            w_index_nxt = rewind ? (r_index - 1'b1) : (r_index + 1'b1);
            w_state_nxt = FETCH;
          end
        end
        default: w_state_nxt = PAUSED;
      endcase
    end
  end

  dffr #(.WIDTH(3)) u_state (
    .clk (clk), .i_rst (reset), .i_d (w_state_nxt), .o_q (r_state)
  );

  dffr #(.WIDTH(ADDR_BITS)) u_index (
    .clk (clk), .i_rst (reset), .i_d (w_index_nxt), .o_q (r_index)
  );

  // Never cleared: reloading from song on every edge gives song_q=song during reset too.
  dffr #(.WIDTH(SONG_BITS)) u_song_q (
    .clk (clk), .i_rst (1'b0), .i_d (song), .o_q (r_song_q)
  );

  dffr #(.WIDTH(NOTE_WIDTH)) u_note (
    .clk (clk), .i_rst (reset), .i_d (w_note_nxt), .o_q (r_note)
  );

  dffr #(.WIDTH(DURATION_WIDTH)) u_duration (
    .clk (clk), .i_rst (reset), .i_d (w_duration_nxt), .o_q (r_duration)
  );

  dffr #(.WIDTH(1)) u_new_note (
    .clk (clk), .i_rst (reset), .i_d (w_new_note_nxt), .o_q (r_new_note)
  );

  dffr #(.WIDTH(1)) u_song_done (
    .clk (clk), .i_rst (reset), .i_d (w_song_done_nxt), .o_q (r_song_done)
  );

  assign rom_addr  = {r_song_q, r_index};
  assign note      = r_note;
  assign duration  = r_duration;
  assign new_note  = r_new_note;
  assign song_done = r_song_done;
  assign index     = r_index;

endmodule

// File: tb/tb_multi_song_reader.sv
// Bench for multi_song_reader: directed scenarios plus randomized song walks
// compared against a note-by-note model of how the song table is traversed.
module tb_multi_song_reader;

  localparam int SB = 2;
  localparam int AB = 5;
  localparam int NW = 6;
  localparam int DW = 6;
  localparam int SLOTS = 1 << AB;

  logic              clk = 1'b0;
  logic              reset;
  logic              play;
  logic [SB-1:0]     song;
  logic              note_done;
  logic              ff;
  logic              rewind;
  logic              loop;
  logic [SB+AB-1:0]  rom_addr;
  logic [NW+DW-1:0]  rom_data;
  logic [NW-1:0]     note;
  logic [DW-1:0]     duration;
  logic              new_note;
  logic              song_done;
  logic [AB-1:0]     index;

  logic [NW+DW-1:0]  rom [0:(1<<(SB+AB))-1];

  int n_checks = 0;
  int n_pass   = 0;
  bit cur_ff   = 1'b0;
  bit cur_rew  = 1'b0;

  multi_song_reader #(
    .SONG_BITS (SB), .ADDR_BITS (AB), .NOTE_WIDTH (NW), .DURATION_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .song      (song),
    .note_done (note_done),
    .ff        (ff),
    .rewind    (rewind),
    .loop      (loop),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note      (note),
    .duration  (duration),
    .new_note  (new_note),
    .song_done (song_done),
    .index     (index)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM: data for an address appears one cycle later.
  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int scale(input int d, input bit halve);
    if (!halve || d == 0) return d;
    return (d / 2 == 0) ? 1 : d / 2;
  endfunction

  function automatic int rom_note(input int s, input int idx);
    return int'(rom[s*SLOTS + idx]) / 64;
  endfunction

  function automatic int rom_dur(input int s, input int idx);
    return int'(rom[s*SLOTS + idx]) % 64;
  endfunction

  task automatic fill_song(input int s, input bit allow_zero);
    for (int i = 0; i < SLOTS; i++) begin
      rom[s*SLOTS + i] = 12'($urandom_range(1, 63) * 64 + $urandom_range(0, 63));
      if (allow_zero && i > 0 && $urandom_range(0, 19) == 0) rom[s*SLOTS + i] = '0;
    end
  endtask

  task automatic do_reset(input int s);
    play = 0; note_done = 0; ff = 0; rewind = 0; loop = 0;
    cur_ff = 0; cur_rew = 0;
    song = SB'(s);
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic wait_new_note(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (new_note) ok = 1;
    end
  endtask

  task automatic expect_note(input int s, input int idx);
    bit ok;
    wait_new_note(8, ok);
    check("new_note_seen", ok, 1);
    check("note", note, rom_note(s, idx));
    check("duration", duration, scale(rom_dur(s, idx), cur_rew | cur_ff));
    check("index", index, idx);
    check("rom_addr", rom_addr, s*SLOTS + idx);
  endtask

  // Sets the mode for the coming ADVANCE (and the next fetch), then ends the note.
  task automatic advance(input bit rew, input bit f, input int idx, output int nidx, output bit ended);
    rewind = rew; ff = f; cur_rew = rew; cur_ff = f;
    note_done = 1; tick(); note_done = 0;
    tick();
    ended = rew ? (idx == 0) : (idx == SLOTS - 1);
    nidx  = ended ? 0 : (rew ? idx - 1 : idx + 1);
    check("song_done_adv", song_done, ended);
    check("index_adv", index, nidx);
  endtask

  task automatic zero_end();
    bit saw = 0;
    bit nn  = 0;
    for (int i = 0; i < 8 && !saw; i++) begin
      tick();
      if (new_note)  nn  = 1;
      if (song_done) saw = 1;
    end
    check("zero_song_done", saw, 1);
    check("zero_no_new_note", nn, 0);
    check("zero_index", index, 0);
  endtask

  task automatic pause_resume(input int s, input int idx);
    bit nn = 0;
    play = 0;
    tick();
    if (new_note) nn = 1;
    note_done = 1; tick(); note_done = 0;
    if (new_note) nn = 1;
    tick();
    if (new_note) nn = 1;
    check("pause_quiet", nn, 0);
    check("pause_index", index, idx);
    play = 1;
    expect_note(s, idx);
  endtask

  task automatic walk(input int s, input int max_notes, input bit rand_modes, input bit pause_ok,
                      output bit ended);
    int idx = 0;
    int nidx;
    bit e;
    bit r;
    bit f;
    ended = 0;
    for (int n = 0; n < max_notes && !ended; n++) begin
      if (rom[s*SLOTS + idx] == '0) begin
        zero_end();
        ended = 1;
      end else begin
        expect_note(s, idx);
        if (pause_ok && $urandom_range(0, 6) == 0) pause_resume(s, idx);
        r = cur_rew; f = cur_ff;
        if (rand_modes) begin
          r = ($urandom_range(0, 9) < 3);
          f = ($urandom_range(0, 9) < 3);
        end
        advance(r, f, idx, nidx, e);
        ended = e;
        idx   = nidx;
      end
    end
  endtask

  initial begin
    bit e;
    int nidx;
    bit lp;
    int s;
    reset = 1; play = 0; song = '0; note_done = 0; ff = 0; rewind = 0; loop = 0;
    for (int i = 0; i < (1 << (SB + AB)); i++) rom[i] = '0;

    // Reset values, then play-to-new_note latency of three edges.
    rom[1*SLOTS + 0] = 12'(12 * 64 + 8);
    do_reset(1);
    check("rst_index", index, 0);
    check("rst_note", note, 0);
    check("rst_duration", duration, 0);
    check("rst_new_note", new_note, 0);
    check("rst_song_done", song_done, 0);
    check("rst_rom_addr", rom_addr, 'h20);
    play = 1;
    tick(); check("lat_c1", new_note, 0);
    tick(); check("lat_c2", new_note, 0);
    tick(); check("lat_c3", new_note, 1);
    check("first_note", note, 12);
    check("first_duration", duration, 8);

    // Fast-forward halving with the zero guard.
    rom[1*SLOTS + 0] = 12'(5 * 64 + 1);
    rom[1*SLOTS + 1] = 12'(6 * 64 + 9);
    do_reset(1);
    ff = 1; cur_ff = 1; play = 1;
    expect_note(1, 0);
    check("ff_dur1", duration, 1);
    advance(0, 1, 0, nidx, e);
    expect_note(1, 1);
    check("ff_dur9", duration, 4);

    // Rewind with zero duration, then rewind off the start of the song.
    rom[1*SLOTS + 0] = 12'(7 * 64 + 0);
    do_reset(1);
    rewind = 1; cur_rew = 1; play = 1;
    expect_note(1, 0);
    check("rew_dur0", duration, 0);
    advance(1, 0, 0, nidx, e);
    tick(); check("rew_end_p1", new_note, 0);
    tick(); check("rew_end_p2", new_note, 0);
    tick(); check("rew_end_restart", new_note, 1);

    // Forward carry out of slot 31, without and with loop.
    fill_song(1, 0);
    do_reset(1);
    play = 1;
    walk(1, SLOTS, 0, 0, e);
    tick(); check("end31_p1", new_note, 0);
    tick(); check("end31_p2", new_note, 0);
    tick(); check("end31_restart", new_note, 1);
    check("end31_restart_idx", index, 0);
    do_reset(1);
    loop = 1; play = 1;
    walk(1, SLOTS, 0, 0, e);
    // song_done shares its cycle with the looped FETCH.
    tick(); check("loop_c1", new_note, 0);
    tick(); check("loop_c2", new_note, 1);
    check("loop_note", note, rom_note(1, 0));
    check("loop_index", index, 0);

    // Terminator entry at slot 4.
    fill_song(2, 0);
    rom[2*SLOTS + 4] = '0;
    do_reset(2);
    play = 1;
    walk(2, 10, 0, 0, e);

    // Song change while waiting on slot 7.
    do_reset(1);
    play = 1;
    walk(1, 7, 0, 0, e);
    expect_note(1, 7);
    song = 2;
    tick();
    check("chg_index", index, 0);
    check("chg_rom_addr", rom_addr, 'h40);
    check("chg_new_note", new_note, 0);
    check("chg_song_done", song_done, 0);
    tick(); check("chg_c2", new_note, 0);
    tick(); check("chg_c3", new_note, 0);
    tick(); check("chg_c4", new_note, 1);
    check("chg_note", note, rom_note(2, 0));

    // Reset and song change landing on an end-of-song ADVANCE: no song_done.
    rewind = 1; cur_rew = 1;
    note_done = 1; tick(); note_done = 0;
    reset = 1; song = 3;
    tick();
    check("rst_mid_song_done", song_done, 0);
    check("rst_mid_index", index, 0);
    check("rst_mid_note", note, 0);
    check("rst_mid_duration", duration, 0);
    check("rst_mid_new_note", new_note, 0);
    check("rst_mid_rom_addr", rom_addr, 'h60);
    reset = 0; play = 0; rewind = 0; cur_rew = 0;
    tick();

    // Randomized walks: random tables, modes, pauses and looping.
    for (int t = 0; t < 12; t++) begin
      s  = $urandom_range(0, 3);
      lp = $urandom_range(0, 1);
      fill_song(s, 1);
      do_reset(s);
      loop    = lp;
      cur_rew = ($urandom_range(0, 3) == 0);
      cur_ff  = ($urandom_range(0, 3) == 0);
      rewind  = cur_rew;
      ff      = cur_ff;
      play    = 1;
      walk(s, 40, 1, 1, e);
      if (e && lp) begin
        tick(); check("rnd_loop_c1", new_note, 0);
        tick(); check("rnd_loop_c2", new_note, 1);
        check("rnd_loop_index", index, 0);
      end
      play = 0;
      tick(); tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
